// File: rtl/mux8_rr_arbiter.sv
// 8-to-1 arbitrating multiplexer with valid/ready handshakes.
// Each output beat carries the index of the channel it came from, so a
// downstream 1-to-8 demux can route it back out using out_sel.
// Arbitration is round-robin from a registered pointer, or fixed
// priority with channel 0 highest, chosen per cycle by fixed_pri.
module mux8_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fixed_pri,
    input  logic [7:0]      in_valid,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel,
    input  logic            out_ready
);

    // Channel most recently granted in round-robin mode; the scan starts
    // one past it. Resets to 7 so channel 0 is scanned first.
    logic [2:0]    ptr;

    logic          load;
    logic          found;
    logic [2:0]    grant_idx;
    logic [7:0]    grant;
    logic [DW-1:0] grant_data;

    // The output register can take a new beat when empty or being drained.
    assign load = ~out_valid | out_ready;

    // Grant selection: scan eight candidates in priority order and keep
    // the first valid one.
    always_comb begin
        logic [2:0] idx;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found      = 1'b0;
        grant_idx  = 3'd0;
        grant      = 8'h00;
        grant_data = '0;
        idx        = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            // Fixed: 0,1,...,7. Round-robin: ptr+1, ..., ptr+8 (wraps mod 8).
            idx = fixed_pri ? 3'(k - 1) : ptr + 3'(k);
            if (!found && in_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
            grant_data       = in_data[grant_idx*DW +: DW];
        end
    end

    // Ready goes only to the granted channel, and never while in reset.
    assign in_ready = (load && rst_n) ? grant : 8'h00;

    // Output register and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr       <= 3'd7;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                if (!fixed_pri) begin
                    ptr <= grant_idx;
                end
            end else begin
                // Empty cycle: drop valid but keep the last data/sel.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
// Inputs change on the falling edge; combinational ready is checked just
// after that, registered outputs 1 time unit after the rising edge.
module tb_mux8_rr_arbiter;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fixed_pri;
    logic [7:0]      in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_sel;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fixed_pri (fixed_pri),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [2:0] sel, input logic [7:0] data);
        check({tag, "_valid"}, 8'(out_valid), 8'h01);
        check({tag, "_sel"}, 8'(out_sel), 8'(sel));
        check({tag, "_data"}, out_data, data);
    endtask

    initial begin
        rst_n     = 1'b0;
        fixed_pri = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'h10 + 8'(i);

        // Reset with every channel requesting.
        tick();
        tick();
        check("rst_out_valid", 8'(out_valid), 8'h00);
        check("rst_in_ready", in_ready, 8'h00);
        check("rst_out_sel", 8'(out_sel), 8'h00);
        check("rst_out_data", out_data, 8'h00);

        // Release; round-robin over all eight, back to 0, no bubbles.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 8'h01);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_beat("rr", 3'(i % 8), 8'h10 + 8'(i % 8));
        end

        // Nothing valid: output empties.
        @(negedge clk);
        in_valid = 8'h00;
        tick();
        check("idle_out_valid", 8'(out_valid), 8'h00);

        // Single channel 5.
        @(negedge clk);
        in_data[5*DW +: DW] = 8'hA5;
        in_valid = 8'h20;
        #1;
        check("ch5_in_ready", in_ready, 8'h20);
        tick();
        check_beat("ch5", 3'd5, 8'hA5);

        // Backpressure for 3 cycles with ch0 and ch3 waiting.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 8'h09;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 8'h00);
            tick();
            check_beat("stall", 3'd5, 8'hA5);
            @(negedge clk);
        end
        // ptr=5: scan 6,7,0 -> channel 0.
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 8'h01);
        tick();
        check_beat("unstall", 3'd0, 8'h10);

        // Fixed priority: ch2 beats ch6 every time.
        @(negedge clk);
        in_data[5*DW +: DW] = 8'h15;
        fixed_pri = 1'b1;
        in_valid  = 8'h44;
        #1;
        check("fix_in_ready", in_ready, 8'h04);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_beat("fix", 3'd2, 8'h12);
        end
        @(negedge clk);
        in_valid = 8'h40;
        #1;
        check("fix6_in_ready", in_ready, 8'h40);
        tick();
        check_beat("fix6", 3'd6, 8'h16);

        // Back to round-robin: ptr was frozen at 0, so channel 1 is next.
        @(negedge clk);
        fixed_pri = 1'b0;
        in_valid  = 8'hFF;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_beat("rr2", 3'(i), 8'h10 + 8'(i));
        end

        // Half-cycle reset pulse mid-stream.
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 8'(out_valid), 8'h00);
        check("mid_rst_in_ready", in_ready, 8'h00);
        check("mid_rst_out_sel", 8'(out_sel), 8'h00);
        #4;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 8'h01);
        tick();
        check_beat("post_rst", 3'd0, 8'h10);
        tick();
        check_beat("post_rst2", 3'd1, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
